// File: rtl/uart_rx_param.sv
// rtl/uart_rx_param.sv - parameterised UART receiver with parity, stop-bit and overrun reporting
module uart_rx_param #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_MODE  = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx_i,
    output logic [DATA_BITS-1:0] data,
    output logic                 ready,
    input  logic                 reset_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = $clog2(DATA_BITS + 1);

    localparam logic [TW-1:0] TICK_MID  = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] TICK_END  = TW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t               state;
    logic                 rx_meta;
    logic                 rxs;
    logic [TW-1:0]        tick;
    logic [BW-1:0]        bit_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 perr_acc;
    logic                 fe_acc;

    // Two-flop synchronizer; flops reset to the idle line level so reset never looks like a start bit
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rx_i;
            rxs     <= rx_meta;
        end
    end

    // Frame FSM plus the consumer handshake; a completion always wins over an acknowledge on ready
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            tick       <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            perr_acc   <= 1'b0;
            fe_acc     <= 1'b0;
            data       <= '0;
            ready      <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (reset_ready) begin
                ready   <= 1'b0;
                overrun <= 1'b0;
            end

            case (state)
                IDLE: begin
                    tick     <= '0;
                    bit_idx  <= '0;
                    perr_acc <= 1'b0;
                    fe_acc   <= 1'b0;
                    if (!rxs) begin
                        state <= START;
                    end
                end

                START: begin
                    if (tick == TICK_MID) begin
                        tick  <= '0;
                        state <= rxs ? IDLE : DATA;
                    end else begin
                        tick <= tick + TW'(1);
                    end
                end

                DATA: begin
                    if (tick == TICK_END) begin
                        tick  <= '0;
                        shreg <= {rxs, shreg[DATA_BITS-1:1]};
                        if (bit_idx == LAST_DATA) begin
                            bit_idx <= '0;
                            state   <= (PARITY_MODE != 0) ? PARITY : STOP;
                        end else begin
                            bit_idx <= bit_idx + BW'(1);
                        end
                    end else begin
                        tick <= tick + TW'(1);
                    end
                end

                PARITY: begin
                    if (tick == TICK_END) begin
                        tick <= '0;
                        // Even: the line bit must equal the data XOR; odd: its inverse
                        if (PARITY_MODE == 2) begin
                            perr_acc <= (rxs == (^shreg));
                        end else begin
                            perr_acc <= (rxs != (^shreg));
                        end
                        state <= STOP;
                    end else begin
                        tick <= tick + TW'(1);
                    end
                end

                STOP: begin
                    if (tick == TICK_END) begin
                        tick <= '0;
                        if (bit_idx == LAST_STOP) begin
                            bit_idx    <= '0;
                            state      <= IDLE;
                            data       <= shreg;
                            parity_err <= perr_acc;
                            frame_err  <= fe_acc | ~rxs;
                            ready      <= 1'b1;
                            // Coinciding acknowledge leaves overrun as it was
                            overrun    <= overrun | (ready & ~reset_ready);
                        end else begin
                            fe_acc  <= fe_acc | ~rxs;
                            bit_idx <= bit_idx + BW'(1);
                        end
                    end else begin
                        tick <= tick + TW'(1);
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_param.sv
// tb/tb_uart_rx_param.sv - scoreboard bench for uart_rx_param in three configurations
module tb_uart_rx_param;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] rx_l = 3'b111;
    logic [2:0] rr = 3'b000;
    logic [2:0] rdy;
    logic [2:0] pe;
    logic [2:0] fe;
    logic [2:0] ov;
    logic [7:0] d0;
    logic [7:0] d1;
    logic [6:0] d2;

    int n_cmp = 0;
    int n_fail = 0;

    typedef struct {
        int         k;
        logic [8:0] d;
        logic       pe;
        logic       fe;
        logic       ov;
    } exp_t;

    exp_t sb_q[$];
    logic ready_m[3];
    logic ovr_m[3];

    always #5 clk = ~clk;

    // Instance 0: defaults (16 clk/bit, 8N1)
    uart_rx_param u0 (
        .clk(clk), .reset(reset), .rx_i(rx_l[0]), .data(d0), .ready(rdy[0]),
        .reset_ready(rr[0]), .parity_err(pe[0]), .frame_err(fe[0]), .overrun(ov[0])
    );

    // Instance 1: 8 data bits, even parity, 8 clk/bit
    uart_rx_param #(.CLKS_PER_BIT(8), .DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1)) u1 (
        .clk(clk), .reset(reset), .rx_i(rx_l[1]), .data(d1), .ready(rdy[1]),
        .reset_ready(rr[1]), .parity_err(pe[1]), .frame_err(fe[1]), .overrun(ov[1])
    );

    // Instance 2: 7 data bits, no parity, 2 stop bits, 8 clk/bit
    uart_rx_param #(.CLKS_PER_BIT(8), .DATA_BITS(7), .PARITY_MODE(0), .STOP_BITS(2)) u2 (
        .clk(clk), .reset(reset), .rx_i(rx_l[2]), .data(d2), .ready(rdy[2]),
        .reset_ready(rr[2]), .parity_err(pe[2]), .frame_err(fe[2]), .overrun(ov[2])
    );

    function automatic int cpb_of(input int k);
        return (k == 0) ? 16 : 8;
    endfunction

    function automatic int nb_of(input int k);
        return (k == 2) ? 7 : 8;
    endfunction

    function automatic int pm_of(input int k);
        return (k == 1) ? 1 : 0;
    endfunction

    function automatic int sb_of(input int k);
        return (k == 2) ? 2 : 1;
    endfunction

    function automatic logic [8:0] data_of(input int k);
        if (k == 0) return {1'b0, d0};
        if (k == 1) return {1'b0, d1};
        return {2'b00, d2};
    endfunction

    task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int k, input logic v, input int cycles);
        rx_l[k] = v;
        repeat (cycles) @(negedge clk);
    endtask

    // Sends one frame and pushes the result the receiver owes for it
    task automatic send(input int k, input logic [8:0] val, input logic pbit,
                        input logic s0, input logic s1);
        int         n;
        int         c;
        logic [8:0] m;
        logic [8:0] dm;
        exp_t       e;
        n  = nb_of(k);
        c  = cpb_of(k);
        m  = (9'd1 << n) - 9'd1;
        dm = val & m;
        e.k  = k;
        e.d  = dm;
        e.pe = (pm_of(k) == 1) ? (pbit != (^dm)) :
               (pm_of(k) == 2) ? (pbit == (^dm)) : 1'b0;
        e.fe = !s0 || (sb_of(k) == 2 && !s1);
        e.ov = ovr_m[k] | ready_m[k];
        ready_m[k] = 1'b1;
        ovr_m[k]   = e.ov;
        sb_q.push_back(e);
        drive(k, 1'b0, c);
        for (int i = 0; i < n; i++) drive(k, dm[i], c);
        if (pm_of(k) != 0) drive(k, pbit, c);
        drive(k, s0, c);
        if (sb_of(k) == 2) drive(k, s1, c);
        drive(k, 1'b1, 2 * c);
    endtask

    task automatic check_output(input int k, input string tag);
        exp_t e;
        for (int i = 0; i < 64 && !rdy[k]; i++) @(negedge clk);
        chk({tag, ".ready"}, {8'd0, rdy[k]}, 9'd1);
        if (sb_q.size() == 0) begin
            chk({tag, ".queue"}, 9'd0, 9'd1);
        end else begin
            e = sb_q.pop_front();
            chk({tag, ".data"}, data_of(k), e.d);
            chk({tag, ".parity_err"}, {8'd0, pe[k]}, {8'd0, e.pe});
            chk({tag, ".frame_err"}, {8'd0, fe[k]}, {8'd0, e.fe});
            chk({tag, ".overrun"}, {8'd0, ov[k]}, {8'd0, e.ov});
        end
    endtask

    task automatic ack(input int k, input string tag);
        rr[k] = 1'b1;
        @(negedge clk);
        rr[k] = 1'b0;
        ready_m[k] = 1'b0;
        ovr_m[k]   = 1'b0;
        chk({tag, ".ack_ready"}, {8'd0, rdy[k]}, 9'd0);
        chk({tag, ".ack_overrun"}, {8'd0, ov[k]}, 9'd0);
    endtask

    task automatic check_cleared(input int k, input string tag);
        chk({tag, ".data"}, data_of(k), 9'd0);
        chk({tag, ".ready"}, {8'd0, rdy[k]}, 9'd0);
        chk({tag, ".flags"}, {6'd0, pe[k], fe[k], ov[k]}, 9'd0);
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            ready_m[k] = 1'b0;
            ovr_m[k]   = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) check_cleared(k, $sformatf("reset%0d", k));
        reset = 1'b0;
        repeat (4) @(negedge clk);

        send(0, 9'h0A5, 1'b0, 1'b1, 1'b1);
        check_output(0, "a5");
        ack(0, "a5");

        rx_l[0] = 1'b0;
        repeat (4) @(negedge clk);
        rx_l[0] = 1'b1;
        repeat (48) @(negedge clk);
        chk("glitch.ready", {8'd0, rdy[0]}, 9'd0);
        chk("glitch.flags", {6'd0, pe[0], fe[0], ov[0]}, 9'd0);
        chk("glitch.data", data_of(0), 9'h0A5);

        send(0, 9'h03C, 1'b0, 1'b0, 1'b1);
        check_output(0, "3c_ferr");
        ack(0, "3c_ferr");
        send(0, 9'h096, 1'b0, 1'b1, 1'b1);
        check_output(0, "96_after_ferr");
        ack(0, "96_after_ferr");

        send(0, 9'h011, 1'b0, 1'b1, 1'b1);
        check_output(0, "ovr_11");
        send(0, 9'h022, 1'b0, 1'b1, 1'b1);
        check_output(0, "ovr_22");
        ack(0, "ovr_ack");

        send(1, 9'h00F, 1'b1, 1'b1, 1'b1);
        check_output(1, "par_bad");
        ack(1, "par_bad");
        send(1, 9'h00F, 1'b0, 1'b1, 1'b1);
        check_output(1, "par_ok");
        ack(1, "par_ok");
        send(1, 9'h0B3, 1'b1, 1'b1, 1'b1);
        check_output(1, "par_b3");
        ack(1, "par_b3");

        send(2, 9'h055, 1'b0, 1'b1, 1'b1);
        check_output(2, "d7s2_ok");
        ack(2, "d7s2_ok");
        send(2, 9'h02A, 1'b0, 1'b1, 1'b0);
        check_output(2, "d7s2_stop2");
        ack(2, "d7s2_stop2");

        rx_l[0] = 1'b0;
        repeat (16) @(negedge clk);
        rx_l[0] = 1'b1;
        repeat (48) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            ready_m[k] = 1'b0;
            ovr_m[k]   = 1'b0;
        end
        check_cleared(0, "midreset");
        repeat (160) @(negedge clk);
        chk("midreset.no_ready", {8'd0, rdy[0]}, 9'd0);
        send(0, 9'h05A, 1'b0, 1'b1, 1'b1);
        check_output(0, "5a_after_reset");

        chk("queue_empty", 9'(sb_q.size()), 9'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
